clear_ram: RTL and testbench

CLEAR_RAM -- requirements
Module: clear_ram

---
 rtl/clear_ram.sv | 131 +++++++++++++
 tb/tb_clear_ram.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clear_ram.sv
// clear_ram: single-port RAM with a hardware clear sweep.
// A sweep writes CLR_VALUE to every word, one word per cycle, while BUSY is
// high; user accesses are ignored during the sweep. Reads have one cycle of
// latency and are flagged by DVALID. Accesses at or beyond MEM_SIZE raise ERR.
// Handshake: an access is accepted on a rising CLK edge where EN=1, CLR=0 and
// the FSM is IDLE (BUSY=0); there is no back-pressure, so DVALID/ERR pulse on
// the cycle after the accepting edge and are never held off.
module clear_ram #(
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    DATA_WIDTH    = 10,
    parameter int                    MEM_SIZE      = 256,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE     = '0,
    parameter bit                    INIT_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  CLR,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  DVALID,
    output logic                  ERR,
    output logic                  BUSY,
    output logic                  DBG_STATE
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W  = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST    = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam state_t                RESET_STATE = INIT_ON_RESET ? S_CLEAR : S_IDLE;

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  addr_ok;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_fire;
    logic                  err_fire;

    assign addr_ok   = ({1'b0, ADDR} < MEM_SIZE_W);
    assign BUSY      = (state == S_CLEAR);
    assign DBG_STATE = state;

    // State register and sweep counter; reset parks the FSM in its start state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic, memory write port selection and access decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = CLR_VALUE;
        rd_fire   = 1'b0;
        err_fire  = 1'b0;
        case (state)
            S_CLEAR: begin
                // CLR is deliberately not looked at here: a sweep never restarts.
                mem_we = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                if (CLR) begin
                    // Clear wins over a simultaneous access, which is dropped.
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end else if (EN) begin
                    if (addr_ok) begin
                        if (WE) begin
                            mem_we    = 1'b1;
                            mem_waddr = ADDR;
                            mem_wdata = Din;
                        end else begin
                            rd_fire = 1'b1;
                        end
                    end else begin
                        err_fire = 1'b1;
                        rd_fire  = !WE;
                    end
                end
            end
        endcase
    end

    // Memory array: no reset, only the sweep or a user write changes it.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read data and status pulses; Dout holds when no read completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Dout   <= '0;
            DVALID <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            DVALID <= rd_fire;
            ERR    <= err_fire;
            if (rd_fire) begin
                Dout <= addr_ok ? mem[ADDR] : '0;
            end
        end
    end

endmodule

// File: tb/tb_clear_ram.sv
// Directed bench for clear_ram: three instances (defaults, MEM_SIZE=200,
// INIT_ON_RESET=0) share data inputs and have separate resets, so the
// instances not under test are parked in reset.
module tb_clear_ram;

  logic       clk;
  logic       rst_n0, rst_n1, rst_n2;
  logic       en, we, clr;
  logic [7:0] addr;
  logic [9:0] din;

  logic [9:0] dout0, dout1, dout2;
  logic       dvalid0, dvalid1, dvalid2;
  logic       err0, err1, err2;
  logic       busy0, busy1, busy2;
  logic       dbg0, dbg1, dbg2;

  int n_cmp;
  int n_fail;

  clear_ram u0 (
    .CLK(clk), .RST_N(rst_n0), .EN(en), .WE(we), .ADDR(addr), .Din(din), .CLR(clr),
    .Dout(dout0), .DVALID(dvalid0), .ERR(err0), .BUSY(busy0), .DBG_STATE(dbg0)
  );

  clear_ram #(.MEM_SIZE(200)) u1 (
    .CLK(clk), .RST_N(rst_n1), .EN(en), .WE(we), .ADDR(addr), .Din(din), .CLR(clr),
    .Dout(dout1), .DVALID(dvalid1), .ERR(err1), .BUSY(busy1), .DBG_STATE(dbg1)
  );

  clear_ram #(.INIT_ON_RESET(1'b0)) u2 (
    .CLK(clk), .RST_N(rst_n2), .EN(en), .WE(we), .ADDR(addr), .Din(din), .CLR(clr),
    .Dout(dout2), .DVALID(dvalid2), .ERR(err2), .BUSY(busy2), .DBG_STATE(dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after a rising edge, outputs are
  // sampled at the same point, well away from the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [7:0] a,
                       input logic [9:0] d, input logic c);
    en = e; we = w; addr = a; din = d; clr = c;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 8'h00, 10'h000, 1'b0);
  endtask

  // count edges until u0 leaves the sweep; optional CLR/read pulse at edge 100
  task automatic count_busy0(input bit repulse, output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin
      if (repulse && n == 99) drive(1'b1, 1'b0, 8'h01, 10'h000, 1'b1);
      else idle_inputs();
      tick();
      n++;
      if (repulse && n == 100) begin
        n_cmp++;
        if (dvalid0 !== 1'b0 || err0 !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_ignore_access: dvalid=%b err=%b, required 0/0", dvalid0, err0);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (dout0 !== 10'h000 || dvalid0 !== 1'b0 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: dout=%h dvalid=%b err=%b, required 000/0/0", dout0, dvalid0, err0);
    end
    n_cmp++;
    if (busy0 !== 1'b1 || dbg0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy_init1: busy=%b state=%b, required 1/1", busy0, dbg0);
    end
    n_cmp++;
    if (busy2 !== 1'b0 || dbg2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_init0: busy=%b state=%b, required 0/0", busy2, dbg2);
    end
  endtask

  task automatic test_init_sweep();
    int n;
    tick();
    rst_n0 = 1'b1;
    count_busy0(1'b0, n);
    n_cmp++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL init_sweep_len: busy for %0d edges, required 256", n);
    end
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 8'(i), 10'h000, 1'b0);
      tick();
      n_cmp++;
      if (dout0 !== 10'h000 || dvalid0 !== 1'b1 || err0 !== 1'b0) begin
        n_fail++;
        $display("FAIL init_read[%0d]: dout=%h dvalid=%b err=%b, required 000/1/0", i, dout0, dvalid0, err0);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] a_tab [3];
    logic [9:0] d_tab [3];
    a_tab = '{8'h00, 8'hFF, 8'h80};
    d_tab = '{10'h001, 10'h3FF, 10'h155};
    drive(1'b1, 1'b1, 8'h10, 10'h2A5, 1'b0);
    tick();
    n_cmp++;
    if (dvalid0 !== 1'b0 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL write_flags: dvalid=%b err=%b, required 0/0", dvalid0, err0);
    end
    drive(1'b1, 1'b0, 8'h10, 10'h000, 1'b0);
    tick();
    n_cmp++;
    if (dout0 !== 10'h2A5 || dvalid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL read_after_write: dout=%h dvalid=%b, required 2a5/1", dout0, dvalid0);
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (dout0 !== 10'h2A5 || dvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL dout_hold: dout=%h dvalid=%b, required 2a5/0", dout0, dvalid0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, a_tab[i], d_tab[i], 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, a_tab[i], 10'h000, 1'b0);
      tick();
      n_cmp++;
      if (dout0 !== d_tab[i] || dvalid0 !== 1'b1 || err0 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_read[%h]: dout=%h dvalid=%b err=%b, required %h/1/0", a_tab[i], dout0, dvalid0, err0, d_tab[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clr_sweep();
    int n;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'(i), 10'h3FF, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 8'h05, 10'h111, 1'b1);
    tick();
    n_cmp++;
    if (busy0 !== 1'b1 || dvalid0 !== 1'b0 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_wins: busy=%b dvalid=%b err=%b, required 1/0/0", busy0, dvalid0, err0);
    end
    count_busy0(1'b1, n);
    n_cmp++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL clr_sweep_len: busy for %0d edges, required 256", n);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 8'(i), 10'h000, 1'b0);
      tick();
      n_cmp++;
      if (dout0 !== 10'h000 || dvalid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_read[%0d]: dout=%h dvalid=%b, required 000/1", i, dout0, dvalid0);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    drive(1'b1, 1'b1, 8'h07, 10'h0AA, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h07, 10'h000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 10'h000, 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 50; i++) tick();
    n_cmp++;
    if (dout0 !== 10'h0AA || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_in_sweep: dout=%h busy=%b, required 0aa/1", dout0, busy0);
    end
    rst_n0 = 1'b0;
    #1;
    n_cmp++;
    if (dout0 !== 10'h000 || dvalid0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: dout=%h dvalid=%b err=%b busy=%b, required 000/0/0/1", dout0, dvalid0, err0, busy0);
    end
    tick();
    rst_n0 = 1'b1;
    count_busy0(1'b0, n);
    n_cmp++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL restart_sweep_len: busy for %0d edges, required 256", n);
    end
    drive(1'b1, 1'b0, 8'h07, 10'h000, 1'b0);
    tick();
    n_cmp++;
    if (dout0 !== 10'h000 || dvalid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_read7: dout=%h dvalid=%b, required 000/1", dout0, dvalid0);
    end
    idle_inputs();
    rst_n0 = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    int n;
    rst_n1 = 1'b1;
    n = 0;
    while (busy1 === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 200) begin
      n_fail++;
      $display("FAIL m200_sweep_len: busy for %0d edges, required 200", n);
    end
    drive(1'b1, 1'b1, 8'd199, 10'h0CC, 1'b0);
    tick();
    n_cmp++;
    if (err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL m200_write199_err: err=%b, required 0", err1);
    end
    drive(1'b1, 1'b1, 8'd210, 10'h155, 1'b0);
    tick();
    n_cmp++;
    if (err1 !== 1'b1 || dvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL m200_write210: err=%b dvalid=%b, required 1/0", err1, dvalid1);
    end
    drive(1'b1, 1'b0, 8'd199, 10'h000, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'd210, 10'h000, 1'b0);
    tick();
    n_cmp++;
    if (err1 !== 1'b1 || dvalid1 !== 1'b1 || dout1 !== 10'h000) begin
      n_fail++;
      $display("FAIL m200_read210: err=%b dvalid=%b dout=%h, required 1/1/000", err1, dvalid1, dout1);
    end
    drive(1'b1, 1'b0, 8'd199, 10'h000, 1'b0);
    tick();
    n_cmp++;
    if (err1 !== 1'b0 || dvalid1 !== 1'b1 || dout1 !== 10'h0CC) begin
      n_fail++;
      $display("FAIL m200_reread199: err=%b dvalid=%b dout=%h, required 0/1/0cc", err1, dvalid1, dout1);
    end
    drive(1'b1, 1'b0, 8'd200, 10'h000, 1'b0);
    tick();
    n_cmp++;
    if (err1 !== 1'b1 || dvalid1 !== 1'b1 || dout1 !== 10'h000) begin
      n_fail++;
      $display("FAIL m200_read200: err=%b dvalid=%b dout=%h, required 1/1/000", err1, dvalid1, dout1);
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (err1 !== 1'b0 || dvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL m200_err_pulse: err=%b dvalid=%b, required 0/0", err1, dvalid1);
    end
    rst_n1 = 1'b0;
  endtask

  task automatic test_no_init();
    tick();
    rst_n2 = 1'b1;
    drive(1'b1, 1'b1, 8'h03, 10'h1E7, 1'b0);
    tick();
    n_cmp++;
    if (busy2 !== 1'b0 || dvalid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL init0_write: busy=%b dvalid=%b, required 0/0", busy2, dvalid2);
    end
    drive(1'b1, 1'b0, 8'h03, 10'h000, 1'b0);
    tick();
    n_cmp++;
    if (busy2 !== 1'b0 || dvalid2 !== 1'b1 || dout2 !== 10'h1E7) begin
      n_fail++;
      $display("FAIL init0_read: busy=%b dvalid=%b dout=%h, required 0/1/1e7", busy2, dvalid2, dout2);
    end
    drive(1'b1, 1'b0, 8'h03, 10'h000, 1'b1);
    tick();
    n_cmp++;
    if (busy2 !== 1'b1 || dvalid2 !== 1'b0 || dout2 !== 10'h1E7) begin
      n_fail++;
      $display("FAIL init0_clr_read_drop: busy=%b dvalid=%b dout=%h, required 1/0/1e7", busy2, dvalid2, dout2);
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    rst_n2 = 1'b0;
    idle_inputs();
    test_reset();
    test_init_sweep();
    test_write_read();
    test_clr_sweep();
    test_reset_mid_sweep();
    test_out_of_range();
    test_no_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
